// File: rtl/audio_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : audio_source_arbiter
// Purpose  : Buffers two stereo sample streams in per-source FIFOs and, on
//            each serializer reload strobe, presents src0, src1, their
//            signed per-channel mix, or silence.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_74a       in   1   sole clock, rising edge
//   reset         in   1   asynchronous, active-high
//   srcN_valid    in   1   source N offers a sample
//   srcN_data     in  32   {left[31:16], right[15:0]}, signed
//   srcN_ready    out  1   source N FIFO not full (registered)
//   mode          in   2   00 src0, 01 src1, 10 mix, 11 mute
//   sample_req    in   1   serializer reload strobe
//   sample_out    out 32   sample presented to the serializer
//   sample_valid  out  1   one-cycle strobe on sample_out update
//   req_dropped   out  1   sticky: a sample_req was lost
//   underrun_cnt  out 16   saturating underrun event count
// Build option
//   AUDIO_ARB_UNDERRUN_CNT_EN : when defined, underrun_cnt and req_dropped
//   are live; otherwise both are tied to zero.
// ============================================================================
module audio_source_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int SAT_MIX    = 1
) (
    input  logic        clk_74a,
    input  logic        reset,
    input  logic        src0_valid,
    input  logic [31:0] src0_data,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [31:0] src1_data,
    output logic        src1_ready,
    input  logic [1:0]  mode,
    input  logic        sample_req,
    output logic [31:0] sample_out,
    output logic        sample_valid,
    output logic        req_dropped,
    output logic [15:0] underrun_cnt
);

    localparam int              c_AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_MIX     = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic        r_pending;
    logic [31:0] r_last [2];
    logic [31:0] r_sample_out;
    logic        r_sample_valid;

    logic [1:0]  w_valid;
    logic [31:0] w_data [2];
    logic [1:0]  w_ready;
    logic [1:0]  w_push;
    logic [1:0]  w_pop;
    logic [1:0]  w_empty;
    logic [1:0]  w_sel;
    logic [31:0] w_head [2];
    logic [31:0] w_result;

    assign w_valid   = {src1_valid, src0_valid};
    assign w_data[0] = src0_data;
    assign w_data[1] = src1_data;
    assign w_push    = w_valid & w_ready;
    // Only sources selected by the latched mode are popped, and only if they hold data.
    assign w_pop     = (r_state == S_FETCH) ? (w_sel & ~w_empty) : 2'b00;

    assign src0_ready   = w_ready[0];
    assign src1_ready   = w_ready[1];
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;

    always_comb begin
        w_sel = 2'b00;
        case (r_mode)
            2'b00:   w_sel = 2'b01;
            2'b01:   w_sel = 2'b10;
            2'b10:   w_sel = 2'b11;
            default: w_sel = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-source FIFOs. Occupancy counter drives a registered not-full flag
    // computed from the next count, so ready never looks at a same-cycle pop.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [31:0]     r_mem [FIFO_DEPTH];
        logic [c_AW-1:0] r_wr_ptr;
        logic [c_AW-1:0] r_rd_ptr;
        logic [c_AW:0]   r_count;
        logic [c_AW:0]   w_count_nxt;
        logic            r_ready;

        always_comb begin
            w_count_nxt = r_count;
            if (w_push[gi] && !w_pop[gi]) begin
                w_count_nxt = r_count + c_CNT_ONE;
            end else if (!w_push[gi] && w_pop[gi]) begin
                w_count_nxt = r_count - c_CNT_ONE;
            end
        end

        always_ff @(posedge clk_74a or posedge reset) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ready  <= 1'b0;
            end else begin
                if (w_push[gi]) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_count <= w_count_nxt;
                r_ready <= (w_count_nxt != c_DEPTH);
            end
        end

        // Storage needs no reset: pointers define what is valid.
        always_ff @(posedge clk_74a) begin
            if (w_push[gi]) r_mem[r_wr_ptr] <= w_data[gi];
        end

        assign w_head[gi]  = r_mem[r_rd_ptr];
        assign w_empty[gi] = (r_count == '0);
        assign w_ready[gi] = r_ready;
    end

    // Signed 16-bit add; clamps on overflow when SAT_MIX is nonzero.
    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if ((SAT_MIX != 0) && (s[16] != s[15])) begin
            return s[16] ? 16'h8000 : 16'h7FFF;
        end
        return s[15:0];
    endfunction

    // r_last doubles as the operand: a pop refreshes it, an underrun keeps it.
    always_comb begin
        w_result = 32'h0;
        case (r_mode)
            2'b00:   w_result = r_last[0];
            2'b01:   w_result = r_last[1];
            2'b10:   w_result = {add16(r_last[0][31:16], r_last[1][31:16]),
                                 add16(r_last[0][15:0],  r_last[1][15:0])};
            default: w_result = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_mode         <= 2'b00;
            r_pending      <= 1'b0;
            r_last[0]      <= 32'h0;
            r_last[1]      <= 32'h0;
            r_sample_out   <= 32'h0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            // A request while busy is remembered once; extras are lost.
            if (r_state != S_IDLE && sample_req) r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (sample_req || r_pending) begin
                        r_state   <= S_FETCH;
                        r_mode    <= mode;
                        // Both a pending and a new request: one is served now,
                        // the other stays pending.
                        r_pending <= sample_req && r_pending;
                    end
                end
                S_FETCH: begin
                    for (int i = 0; i < 2; i++) begin
                        if (w_pop[i]) r_last[i] <= w_head[i];
                    end
                    r_state <= S_MIX;
                end
                S_MIX: begin
                    r_sample_out   <= w_result;
                    r_sample_valid <= 1'b1;
                    r_state        <= S_PRESENT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AUDIO_ARB_UNDERRUN_CNT_EN
    logic        w_underrun;
    logic        w_drop;
    logic [15:0] r_underrun_cnt;
    logic        r_req_dropped;

    // Any empty selected source makes the whole sample one underrun event.
    assign w_underrun = (r_state == S_FETCH) && (|(w_sel & w_empty));
    assign w_drop     = sample_req && r_pending && (r_state != S_IDLE);

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            r_underrun_cnt <= 16'h0;
            r_req_dropped  <= 1'b0;
        end else begin
            if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'h1;
            end
            if (w_drop) r_req_dropped <= 1'b1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
    assign req_dropped  = r_req_dropped;
`else
    assign underrun_cnt = 16'h0;
    assign req_dropped  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_source_arbiter
// Purpose  : Directed self-checking bench for audio_source_arbiter
//            (FIFO_DEPTH=4, SAT_MIX=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_source_arbiter;

`ifdef AUDIO_ARB_UNDERRUN_CNT_EN
    localparam int c_CNT_EN = 1;
`else
    localparam int c_CNT_EN = 0;
`endif

    logic        clk_74a = 1'b0;
    logic        reset;
    logic        src0_valid, src1_valid;
    logic [31:0] src0_data, src1_data;
    logic        src0_ready, src1_ready;
    logic [1:0]  mode;
    logic        sample_req;
    logic [31:0] sample_out;
    logic        sample_valid;
    logic        req_dropped;
    logic [15:0] underrun_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    int p0;

    always #5 clk_74a = ~clk_74a;

    always @(negedge clk_74a) begin
        if (sample_valid === 1'b1) n_pulses++;
    end

    audio_source_arbiter #(
        .FIFO_DEPTH (4),
        .SAT_MIX    (1)
    ) u_dut (
        .clk_74a      (clk_74a),
        .reset        (reset),
        .src0_valid   (src0_valid),
        .src0_data    (src0_data),
        .src0_ready   (src0_ready),
        .src1_valid   (src1_valid),
        .src1_data    (src1_data),
        .src1_ready   (src1_ready),
        .mode         (mode),
        .sample_req   (sample_req),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .req_dropped  (req_dropped),
        .underrun_cnt (underrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_74a);
        #1;
    endtask

    task automatic push(input int src, input logic [31:0] d);
        if (src == 0) begin
            src0_valid = 1'b1; src0_data = d;
        end else begin
            src1_valid = 1'b1; src1_data = d;
        end
        tick();
        src0_valid = 1'b0;
        src1_valid = 1'b0;
    endtask

    // Pulse sample_req and check the strobe lands exactly three cycles later.
    task automatic run_req(input string tag, input logic [31:0] exp);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        check({tag, "_v1"}, {31'h0, sample_valid}, 32'h0);
        tick();
        check({tag, "_v2"}, {31'h0, sample_valid}, 32'h0);
        tick();
        check({tag, "_v3"}, {31'h0, sample_valid}, 32'h1);
        check({tag, "_out"}, sample_out, exp);
        tick();
    endtask

    initial begin
        reset = 1'b1; src0_valid = 1'b0; src1_valid = 1'b0;
        src0_data = '0; src1_data = '0; mode = 2'b00; sample_req = 1'b0;
        tick(); tick();
        check("rst_out", sample_out, 32'h0);
        check("rst_valid", {31'h0, sample_valid}, 32'h0);
        reset = 1'b0;
        tick();
        check("rst_rdy0", {31'h0, src0_ready}, 32'h1);
        check("rst_rdy1", {31'h0, src1_ready}, 32'h1);
        check("rst_ucnt", {16'h0, underrun_cnt}, 32'h0);
        check("rst_drop", {31'h0, req_dropped}, 32'h0);

        // src0 only
        mode = 2'b00;
        push(0, 32'h1234ABCD);
        run_req("src0", 32'h1234ABCD);
        check("src0_ucnt", {16'h0, underrun_cnt}, 32'h0);

        // mix with saturation, plain, and negative
        mode = 2'b10;
        push(0, 32'h70008001); push(1, 32'h2000FFFE);
        run_req("mix_sat", 32'h7FFF8000);
        push(0, 32'h00010002); push(1, 32'h00030004);
        run_req("mix_add", 32'h00040006);
        push(0, 32'hFFFF0001); push(1, 32'hFFFF0001);
        run_req("mix_neg", 32'hFFFE0002);
        check("mix_ucnt", {16'h0, underrun_cnt}, 32'h0);

        // src1 then underrun repeating last sample
        mode = 2'b01;
        push(1, 32'h00550066);
        run_req("src1", 32'h00550066);
        check("src1_ucnt0", {16'h0, underrun_cnt}, 32'h0);
        run_req("src1_ur", 32'h00550066);
        check("src1_ucnt1", {16'h0, underrun_cnt}, c_CNT_EN);

        // mix with both empty: one event, last samples summed
        mode = 2'b10;
        run_req("mix_ur", 32'h00540067);
        check("mix_ur_ucnt", {16'h0, underrun_cnt}, 2 * c_CNT_EN);

        // mute: no pop, no underrun; the queued sample survives
        mode = 2'b11;
        push(0, 32'hDEAD0001);
        run_req("mute", 32'h0);
        check("mute_ucnt", {16'h0, underrun_cnt}, 2 * c_CNT_EN);
        mode = 2'b00;
        run_req("after_mute", 32'hDEAD0001);
        check("after_mute_ucnt", {16'h0, underrun_cnt}, 2 * c_CNT_EN);

        // mode change while busy is ignored until next request
        push(0, 32'h11112222);
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        mode = 2'b11;
        tick(); tick();
        check("mchg_valid", {31'h0, sample_valid}, 32'h1);
        check("mchg_out", sample_out, 32'h11112222);
        tick();
        mode = 2'b00;

        // fill to full, rejected push, then drain in order
        push(0, 32'hA0000001); push(0, 32'hA0000002); push(0, 32'hA0000003);
        check("full_rdy3", {31'h0, src0_ready}, 32'h1);
        push(0, 32'hA0000004);
        check("full_rdy4", {31'h0, src0_ready}, 32'h0);
        push(0, 32'hBADBAD00);
        check("full_rdy5", {31'h0, src0_ready}, 32'h0);
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        check("full_rdy_fetch", {31'h0, src0_ready}, 32'h0);
        tick();
        check("full_rdy_pop", {31'h0, src0_ready}, 32'h1);
        tick();
        check("drain1", sample_out, 32'hA0000001);
        tick();
        run_req("drain2", 32'hA0000002);
        run_req("drain3", 32'hA0000003);
        run_req("drain4", 32'hA0000004);
        run_req("drain_ur", 32'hA0000004);
        check("drain_ucnt", {16'h0, underrun_cnt}, 3 * c_CNT_EN);

        // three back-to-back requests: two served, one dropped
        mode = 2'b11;
        p0 = n_pulses;
        sample_req = 1'b1; tick(); tick(); tick(); sample_req = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("drop_pulses", n_pulses - p0, 32'd2);
        check("drop_flag", {31'h0, req_dropped}, c_CNT_EN);

        // reset during MIX aborts cleanly and empties FIFOs
        mode = 2'b10;
        push(0, 32'h01010101); push(0, 32'h02020202); push(1, 32'h03030303);
        sample_req = 1'b1; tick(); sample_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("mrst_out", sample_out, 32'h0);
        check("mrst_valid", {31'h0, sample_valid}, 32'h0);
        check("mrst_ucnt", {16'h0, underrun_cnt}, 32'h0);
        check("mrst_drop", {31'h0, req_dropped}, 32'h0);
        tick();
        check("mrst_valid2", {31'h0, sample_valid}, 32'h0);
        reset = 1'b0;
        tick();
        check("mrst_rdy0", {31'h0, src0_ready}, 32'h1);
        check("mrst_rdy1", {31'h0, src1_ready}, 32'h1);
        check("mrst_valid3", {31'h0, sample_valid}, 32'h0);
        mode = 2'b00;
        run_req("mrst_empty", 32'h0);
        check("mrst_ucnt2", {16'h0, underrun_cnt}, c_CNT_EN);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
